// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the pipeline/multi-cycle unit and the write-port arbiter.
// Handshake: the secondary source transfers {s_rw,s_din} on a posedge where
// s_valid && s_ready are both high; s_valid and the payload must stay stable
// until that edge. The primary source has no handshake: p_we is sampled every
// cycle and must be 0 while stall_req is 1.
interface regfile_wb_arbiter_if;
    logic        p_we;
    logic [4:0]  p_rw;
    logic [31:0] p_din;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_rw;
    logic [31:0] s_din;
    logic        claim_valid;
    logic [4:0]  claim_rw;
    logic [31:0] busy;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_din;
    logic        err;

    // Writeback sources and regfile side as seen from outside the arbiter
    modport master (
        output p_we, p_rw, p_din, s_valid, s_rw, s_din, claim_valid, claim_rw,
        input  s_ready, busy, stall_req, rf_we, rf_rw, rf_din, err
    );

    // The arbiter itself
    modport slave (
        input  p_we, p_rw, p_din, s_valid, s_rw, s_din, claim_valid, claim_rw,
        output s_ready, busy, stall_req, rf_we, rf_rw, rf_din, err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: the in-order pipeline writeback has priority, a
// multi-cycle unit queues its results in a small FIFO, a busy scoreboard tracks
// registers reserved by that unit, and a one-cycle stall is requested when the
// FIFO head has been starved for STARVE_LIMIT cycles.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    // FIFO storage: entry = {rw, din}
    logic [36:0]  mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         push;
    logic [4:0]   head_rw;
    logic [31:0]  head_din;

    logic         p_eff;
    logic         claim_eff;
    logic         head_grant;
    logic         prim_grant;
    logic         starved;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          stall_q;
    logic          stall_nxt;
    logic [31:0]   busy_q;
    logic [31:0]   busy_nxt;
    logic          err_q;
    logic          err_nxt;
    logic          rf_we_q;
    logic [4:0]    rf_rw_q;
    logic [31:0]   rf_din_q;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push     = bus.s_valid && !full;
    assign head_rw  = mem[rd_ptr[AW-1:0]][36:32];
    assign head_din = mem[rd_ptr[AW-1:0]][31:0];

    assign bus.s_ready   = !full;
    assign bus.busy      = busy_q;
    assign bus.stall_req = stall_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rw     = rf_rw_q;
    assign bus.rf_din    = rf_din_q;
    assign bus.err       = err_q;

    // Grant: a stall cycle forces the head; otherwise primary wins, then the head
    always_comb begin
        p_eff      = bus.p_we && (bus.p_rw != 5'd0);
        claim_eff  = bus.claim_valid && (bus.claim_rw != 5'd0);
        head_grant = 1'b0;
        prim_grant = 1'b0;
        if (!empty && (stall_q || !p_eff)) begin
            head_grant = 1'b1;
        end else if (p_eff) begin
            prim_grant = 1'b1;
        end
        starved = !empty && !head_grant;
    end

    // Scoreboard, starvation counter, stall request and sticky error next state
    always_comb begin
        busy_nxt = busy_q;
        if (head_grant) begin
            busy_nxt = busy_nxt & ~(32'd1 << head_rw);
        end
        // A claim landing on the bit being released keeps it reserved
        if (claim_eff) begin
            busy_nxt = busy_nxt | (32'd1 << bus.claim_rw);
        end

        cnt_nxt   = starved ? cnt_q + CW'(1) : '0;
        stall_nxt = starved && (cnt_q == CW'(STARVE_LIMIT - 1));

        err_nxt = err_q;
        if (stall_q && p_eff) begin
            err_nxt = 1'b1;
        end
        if (claim_eff && busy_q[bus.claim_rw]) begin
            err_nxt = 1'b1;
        end
        if (p_eff && busy_q[bus.p_rw]) begin
            err_nxt = 1'b1;
        end
    end

    // FIFO payload write; contents are don't-care until pointed at
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bus.s_rw, bus.s_din};
        end
    end

    // FIFO pointers; the head is popped whenever it is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (head_grant) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Registered regfile write port; writes to $0 become no-writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q  <= 1'b0;
            rf_rw_q  <= '0;
            rf_din_q <= '0;
        end else if (prim_grant) begin
            rf_we_q  <= 1'b1;
            rf_rw_q  <= bus.p_rw;
            rf_din_q <= bus.p_din;
        end else if (head_grant && (head_rw != 5'd0)) begin
            rf_we_q  <= 1'b1;
            rf_rw_q  <= head_rw;
            rf_din_q <= head_din;
        end else begin
            rf_we_q  <= 1'b0;
        end
    end

    // Control state: scoreboard, starvation counter, stall request, error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_nxt;
            cnt_q   <= cnt_nxt;
            stall_q <= stall_nxt;
            err_q   <= err_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based behavioural model.
module tb_regfile_wb_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [36:0] mq [$];
    logic [31:0] m_busy;
    int          m_cnt;
    logic        m_stall;
    logic        m_we;
    logic [4:0]  m_rw;
    logic [31:0] m_din;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.p_we        = 1'b0;
        bus.p_rw        = '0;
        bus.p_din       = '0;
        bus.s_valid     = 1'b0;
        bus.s_rw        = '0;
        bus.s_din       = '0;
        bus.claim_valid = 1'b0;
        bus.claim_rw    = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy  = '0;
        m_cnt   = 0;
        m_stall = 1'b0;
        m_we    = 1'b0;
        m_rw    = '0;
        m_din   = '0;
        m_err   = 1'b0;
    endtask

    // Advance the model by one posedge using the inputs currently driven
    task automatic model_edge();
        int          sz;
        logic        p_eff;
        logic        claim_eff;
        logic        acc;
        logic        head_g;
        logic        prim_g;
        logic        starved;
        logic [36:0] h;
        sz        = mq.size();
        p_eff     = bus.p_we && (bus.p_rw != 0);
        claim_eff = bus.claim_valid && (bus.claim_rw != 0);
        acc       = bus.s_valid && (sz < DEPTH);
        head_g    = (sz > 0) && (m_stall || !p_eff);
        prim_g    = p_eff && !head_g;
        h         = (sz > 0) ? mq[0] : 37'd0;
        if (p_eff && (m_stall || m_busy[bus.p_rw])) m_err = 1'b1;
        if (claim_eff && m_busy[bus.claim_rw]) m_err = 1'b1;
        if (prim_g) begin
            m_we = 1'b1; m_rw = bus.p_rw; m_din = bus.p_din;
        end else if (head_g && h[36:32] != 0) begin
            m_we = 1'b1; m_rw = h[36:32]; m_din = h[31:0];
        end else begin
            m_we = 1'b0;
        end
        if (head_g) m_busy[h[36:32]] = 1'b0;
        if (claim_eff) m_busy[bus.claim_rw] = 1'b1;
        starved = (sz > 0) && !head_g;
        m_stall = starved && (m_cnt == STARVE_LIMIT - 1);
        m_cnt   = starved ? m_cnt + 1 : 0;
        if (head_g) void'(mq.pop_front());
        if (acc) mq.push_back({bus.s_rw, bus.s_din});
    endtask

    task automatic check_all();
        chk("rf_we", 32'(bus.rf_we), 32'(m_we));
        chk("rf_rw", 32'(bus.rf_rw), 32'(m_rw));
        chk("rf_din", bus.rf_din, m_din);
        chk("busy", bus.busy, m_busy);
        chk("stall_req", 32'(bus.stall_req), 32'(m_stall));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("s_ready", 32'(bus.s_ready), 32'(mq.size() < DEPTH));
    endtask

    task automatic check_reset_vals();
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_rw", 32'(bus.rf_rw), 32'd0);
        chk("rst_rf_din", bus.rf_din, 32'd0);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_stall", 32'(bus.stall_req), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    endtask

    // One clock cycle: model update, edge, sample 1 time unit later
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset applied mid-cycle, released away from the edge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        chk("post_rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("post_rst_rf_we", 32'(bus.rf_we), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_reset_vals();
        rst_n = 1'b1;
        step();

        // Primary only
        bus.p_we = 1'b1; bus.p_rw = 5'd8; bus.p_din = 32'h1234;
        step();
        chk("prim_we", 32'(bus.rf_we), 32'd1);
        chk("prim_rw", 32'(bus.rf_rw), 32'd8);
        chk("prim_din", bus.rf_din, 32'h1234);
        bus.p_rw = 5'd0; bus.p_din = 32'h5555;
        step();
        chk("prim_r0_we", 32'(bus.rf_we), 32'd0);
        chk("prim_r0_hold", 32'(bus.rf_rw), 32'd8);

        // Secondary only, with a reservation
        idle_inputs();
        bus.claim_valid = 1'b1; bus.claim_rw = 5'd9;
        bus.s_valid = 1'b1; bus.s_rw = 5'd9; bus.s_din = 32'hCAFE;
        step();
        chk("sec_busy_set", 32'(bus.busy[9]), 32'd1);
        chk("sec_no_bypass", 32'(bus.rf_we), 32'd0);
        idle_inputs();
        step();
        chk("sec_we", 32'(bus.rf_we), 32'd1);
        chk("sec_rw", 32'(bus.rf_rw), 32'd9);
        chk("sec_din", bus.rf_din, 32'hCAFE);
        chk("sec_busy_clr", 32'(bus.busy[9]), 32'd0);
        step();
        chk("sec_done", 32'(bus.rf_we), 32'd0);

        // Conflict: primary every cycle, FIFO fills, head starves into a stall
        bus.p_we = 1'b1; bus.p_rw = 5'd3; bus.p_din = 32'h33;
        bus.s_valid = 1'b1; bus.s_rw = 5'd10; bus.s_din = 32'hA0;
        step();
        bus.s_rw = 5'd11; bus.s_din = 32'hB0;
        step();
        chk("full_s_ready", 32'(bus.s_ready), 32'd0);
        bus.s_rw = 5'd12; bus.s_din = 32'hC0;
        step();
        chk("full_reject", 32'(bus.s_ready), 32'd0);
        bus.s_valid = 1'b0;
        step();
        chk("starve_3", 32'(bus.stall_req), 32'd0);
        step();
        chk("starve_stall", 32'(bus.stall_req), 32'd1);
        bus.p_we = 1'b0;
        step();
        chk("stall_head_rw", 32'(bus.rf_rw), 32'd10);
        chk("stall_head_din", bus.rf_din, 32'hA0);
        chk("stall_one_cycle", 32'(bus.stall_req), 32'd0);
        chk("stall_no_err", 32'(bus.err), 32'd0);

        // Second starvation, this time violated by the pipeline
        bus.p_we = 1'b1; bus.p_rw = 5'd4; bus.p_din = 32'h44;
        repeat (3) step();
        chk("starve2_pre", 32'(bus.stall_req), 32'd0);
        step();
        chk("starve2_stall", 32'(bus.stall_req), 32'd1);
        bus.p_din = 32'h4444;
        step();
        chk("viol_err", 32'(bus.err), 32'd1);
        chk("viol_head_rw", 32'(bus.rf_rw), 32'd11);
        chk("viol_head_din", bus.rf_din, 32'hB0);
        bus.p_we = 1'b0;
        step();
        chk("viol_prim_lost", 32'(bus.rf_we), 32'd0);

        // Scoreboard: set wins over clear, then a WAW primary write
        do_reset();
        bus.s_valid = 1'b1; bus.s_rw = 5'd5; bus.s_din = 32'h55;
        step();
        idle_inputs();
        bus.claim_valid = 1'b1; bus.claim_rw = 5'd5;
        step();
        chk("sb_set_wins", 32'(bus.busy[5]), 32'd1);
        chk("sb_grant_rw", 32'(bus.rf_rw), 32'd5);
        chk("sb_no_err", 32'(bus.err), 32'd0);
        idle_inputs();
        bus.p_we = 1'b1; bus.p_rw = 5'd5; bus.p_din = 32'h77;
        step();
        chk("waw_err", 32'(bus.err), 32'd1);
        chk("waw_we", 32'(bus.rf_we), 32'd1);
        chk("waw_din", bus.rf_din, 32'h77);
        chk("waw_busy_kept", 32'(bus.busy[5]), 32'd1);

        // Double claim
        do_reset();
        bus.claim_valid = 1'b1; bus.claim_rw = 5'd7;
        step();
        step();
        chk("dbl_claim_err", 32'(bus.err), 32'd1);
        chk("dbl_claim_busy", 32'(bus.busy[7]), 32'd1);
        do_reset();

        // Randomized legal traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            logic [4:0] pr;
            logic [4:0] cr;
            pr = 5'($urandom_range(0, 31));
            cr = 5'($urandom_range(0, 31));
            bus.p_we        = !m_stall && ($urandom_range(0, 3) != 0) && !m_busy[pr];
            bus.p_rw        = pr;
            bus.p_din       = $urandom;
            bus.claim_valid = ($urandom_range(0, 3) == 0) && !m_busy[cr];
            bus.claim_rw    = cr;
            bus.s_valid     = 1'($urandom_range(0, 1));
            bus.s_rw        = 5'($urandom_range(0, 31));
            bus.s_din       = $urandom;
            step();
            if (i == 200) begin
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
